// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family.
// Direction/mode encodings plus a load-value clamp.
package counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam bit   MODE_WRAP = 1'b0;
    localparam bit   MODE_SAT  = 1'b1;

    function automatic logic [31:0] clamp_max(
        input logic [31:0] val,
        input logic [31:0] max_val
    );
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/updown_next.sv
// Next-count and wrap-event logic for the up/down counter.
// Purely combinational; limits come from MAX_VAL, not natural overflow.
module updown_next
    import counter_pkg::*;
#(
    parameter int unsigned          WIDTH    = 3,
    parameter logic [WIDTH-1:0]     MAX_VAL  = WIDTH'((64'd1 << WIDTH) - 64'd1),
    parameter bit                   SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             sel,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_next,
    output logic             wrap_next
);

    always_comb begin
        cnt_next  = cnt;
        wrap_next = 1'b0;
        if (load) begin
            cnt_next = WIDTH'(clamp_max(32'(load_val), 32'(MAX_VAL)));
        end else if (en) begin
            if (sel == DIR_UP) begin
                if (cnt >= MAX_VAL) begin
                    if (SATURATE == MODE_WRAP) begin
                        cnt_next  = '0;
                        wrap_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + WIDTH'(1);
                end
            end else begin
                if (cnt == '0) begin
                    if (SATURATE == MODE_WRAP) begin
                        cnt_next  = MAX_VAL;
                        wrap_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate and terminal count.
// Holds the cnt and wrap registers; next-state logic lives in updown_next.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned          WIDTH    = 3,
    parameter logic [WIDTH-1:0]     MAX_VAL  = WIDTH'((64'd1 << WIDTH) - 64'd1),
    parameter bit                   SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;

    updown_next #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .cnt       (cnt_q),
        .sel       (sel),
        .en        (en),
        .load      (load),
        .load_val  (load_val),
        .cnt_next  (cnt_d),
        .wrap_next (wrap_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    // tc tracks sel live so a direction flip is visible before the next edge
    always_comb begin
        tc = ((sel == DIR_UP)   && (cnt_q == MAX_VAL)) ||
             ((sel == DIR_DOWN) && (cnt_q == '0));
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: wrap, saturate and modulus builds.
// Expected values are hand-computed constants and simple arithmetic.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sel;
    logic       load;
    logic [3:0] lv;

    logic [2:0] w_cnt;
    logic       w_tc;
    logic       w_wrap;
    logic [2:0] s_cnt;
    logic       s_tc;
    logic       s_wrap;
    logic [3:0] m_cnt;
    logic       m_tc;
    logic       m_wrap;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(3), .SATURATE(1'b0)) u_w (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .load(load),
        .load_val(lv[2:0]), .cnt(w_cnt), .tc(w_tc), .wrap(w_wrap)
    );

    param_updown_counter #(.WIDTH(3), .SATURATE(1'b1)) u_s (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .load(load),
        .load_val(lv[2:0]), .cnt(s_cnt), .tc(s_tc), .wrap(s_wrap)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_m (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .load(load),
        .load_val(lv), .cnt(m_cnt), .tc(m_tc), .wrap(m_wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_v;
        rst  = 1'b0;
        en   = 1'b0;
        sel  = 1'b0;
        load = 1'b0;
        lv   = '0;

        // 1: reset, then count up through the wrap
        step();
        step();
        check("rst_cnt", 32'(w_cnt), 0);
        check("rst_wrap", 32'(w_wrap), 0);
        rst = 1'b1;
        en  = 1'b1;
        sel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_v = (i + 1) % 8;
            check($sformatf("up_cnt%0d", i), 32'(w_cnt), 32'(exp_v));
            check($sformatf("up_wrap%0d", i), 32'(w_wrap), (i == 7) ? 1 : 0);
            check($sformatf("up_tc%0d", i), 32'(w_tc), (exp_v == 7) ? 1 : 0);
        end

        // 2: load 2, count down through 0
        load = 1'b1;
        lv   = 4'd2;
        step();
        check("ld2_cnt", 32'(w_cnt), 2);
        load = 1'b0;
        sel  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_v = (i == 0) ? 1 : (i == 1) ? 0 : (i == 2) ? 7 : 6;
            check($sformatf("dn_cnt%0d", i), 32'(w_cnt), 32'(exp_v));
            check($sformatf("dn_wrap%0d", i), 32'(w_wrap), (i == 2) ? 1 : 0);
            check($sformatf("dn_tc%0d", i), 32'(w_tc), (exp_v == 0) ? 1 : 0);
        end

        // 3: saturating build holds at both ends
        load = 1'b1;
        lv   = 4'd6;
        sel  = 1'b0;
        step();
        check("sat_ld6", 32'(s_cnt), 6);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("sat_up%0d", i), 32'(s_cnt), 7);
            check($sformatf("sat_upw%0d", i), 32'(s_wrap), 0);
        end
        check("sat_tc_hi", 32'(s_tc), 1);
        load = 1'b1;
        lv   = 4'd1;
        step();
        load = 1'b0;
        sel  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("sat_dn%0d", i), 32'(s_cnt), 0);
            check($sformatf("sat_dnw%0d", i), 32'(s_wrap), 0);
        end
        check("sat_tc_lo", 32'(s_tc), 1);

        // 4: modulus 10 in a 4-bit counter
        load = 1'b1;
        lv   = 4'd0;
        sel  = 1'b0;
        step();
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_v = (i + 1) % 10;
            check($sformatf("mod_cnt%0d", i), 32'(m_cnt), 32'(exp_v));
            check($sformatf("mod_wrap%0d", i), 32'(m_wrap), (i == 9) ? 1 : 0);
        end
        load = 1'b1;
        lv   = 4'd14;
        step();
        check("mod_clamp", 32'(m_cnt), 9);
        check("mod_clamp_tc", 32'(m_tc), 1);
        check("mod_clamp_wrap", 32'(m_wrap), 0);

        // 5: load beats enable, then hold
        load = 1'b1;
        en   = 1'b1;
        lv   = 4'd5;
        step();
        check("pri_cnt", 32'(w_cnt), 5);
        load = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_cnt%0d", i), 32'(w_cnt), 5);
            check($sformatf("hold_wrap%0d", i), 32'(w_wrap), 0);
        end
        load = 1'b1;
        lv   = 4'd0;
        step();
        load = 1'b0;
        sel  = 1'b0;
        #1;
        check("tc_sel_up", 32'(w_tc), 0);
        sel  = 1'b1;
        #1;
        check("tc_sel_dn", 32'(w_tc), 1);

        // 6: async reset clears a live wrap pulse and a mid count
        load = 1'b1;
        lv   = 4'd7;
        step();
        load = 1'b0;
        en   = 1'b1;
        sel  = 1'b0;
        step();
        check("pre_rst_wrap", 32'(w_wrap), 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_wrap", 32'(w_wrap), 0);
        check("arst_cnt0", 32'(w_cnt), 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_cnt", 32'(w_cnt), 4);
        #3;
        rst = 1'b0;
        #1;
        check("arst_cnt", 32'(w_cnt), 0);
        check("arst_wrap2", 32'(w_wrap), 0);
        #2;
        rst = 1'b1;
        step();
        check("resume1", 32'(w_cnt), 1);
        step();
        check("resume2", 32'(w_cnt), 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
